// File: rtl/majority_arb_pkg.sv
// Shared constants for the majority-vote arbiter: FSM state codes,
// vote/id widths and a small index-wrapping helper for the round-robin scan.
package majority_arb_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] EVAL = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam int VOTE_W = 5;
    localparam int ID_W   = 3;

    // Returns (base + offset) mod n for base < n and offset < n.
    function automatic int wrapIndex(input int base, input int offset, input int n);
        int sum;
        sum = base + offset;
        if (sum >= n) begin
            sum = sum - n;
        end
        return sum;
    endfunction

endpackage

// File: rtl/majority5_eval.sv
// Combinational 5-input majority built as an 8:1 mux: the upper three vote
// bits choose what the lower two bits still have to contribute.
module majority5_eval
    import majority_arb_pkg::*;
(
    input  logic [VOTE_W-1:0] vote_i,
    output logic              majority_o
);

    logic       andLow;
    logic       orLow;
    logic [7:0] muxData;

    // Index = number pattern of vote[4:2]; entry tells how vote[1:0] completes a 3-of-5 majority.
    always_comb begin
        andLow     = vote_i[1] & vote_i[0];
        orLow      = vote_i[1] | vote_i[0];
        muxData    = {1'b1, orLow, orLow, andLow, orLow, andLow, andLow, 1'b0};
        majority_o = muxData[vote_i[4:2]];
    end

endmodule

// File: rtl/majority_vote_arbiter.sv
// Round-robin sequencer that shares one majority evaluator among N_REQ
// requesters. Each transaction walks IDLE -> LOAD -> EVAL -> DONE; a requester
// dropping req while granted (LOAD/EVAL) aborts it without a result.
module majority_vote_arbiter
    import majority_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*VOTE_W-1:0] vote_data,
    output logic [N_REQ-1:0]        grant,
    output logic [N_REQ-1:0]        ack,
    output logic                    result_valid,
    output logic                    result,
    output logic [ID_W-1:0]         result_id,
    output logic [CNT_W-1:0]        served_cnt
);

    logic [1:0]        state_q,        state_d;
    logic [ID_W-1:0]   rr_ptr_q,       rr_ptr_d;
    logic [ID_W-1:0]   sel_q,          sel_d;
    logic [N_REQ-1:0]  grant_q,        grant_d;
    logic [N_REQ-1:0]  ack_q,          ack_d;
    logic              result_valid_q, result_valid_d;
    logic              result_q,       result_d;
    logic [ID_W-1:0]   result_id_q,    result_id_d;
    logic [CNT_W-1:0]  served_cnt_q,   served_cnt_d;
    logic [VOTE_W-1:0] vote_reg_q,     vote_reg_d;

    logic              found;
    logic [ID_W-1:0]   pickIdx;
    logic [N_REQ-1:0]  pickOneHot;
    logic              reqSel;
    logic [VOTE_W-1:0] selVote;
    logic [ID_W-1:0]   nextPtr;
    logic              majOut;

    majority5_eval u_eval (
        .vote_i     (vote_reg_q),
        .majority_o (majOut)
    );

    // Round-robin pick: first asserted req scanning from rr_ptr upward with wrap.
    always_comb begin
        found   = 1'b0;
        pickIdx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (!found && req[j] && (j == wrapIndex(int'(rr_ptr_q), k, N_REQ))) begin
                    found   = 1'b1;
                    pickIdx = ID_W'(j);
                end
            end
        end
        for (int j = 0; j < N_REQ; j++) begin
            pickOneHot[j] = (pickIdx == ID_W'(j));
        end
    end

    // Decode the currently selected requester: its req level, its vote slice and the following pointer.
    always_comb begin
        reqSel  = 1'b0;
        selVote = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (sel_q == ID_W'(j)) begin
                reqSel  = req[j];
                selVote = vote_data[VOTE_W*j +: VOTE_W];
            end
        end
        nextPtr = (int'(sel_q) >= N_REQ - 1) ? '0 : sel_q + ID_W'(1);
    end

    // Transaction FSM; ack/result_valid are prepared in EVAL so they appear registered during DONE.
    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        sel_d          = sel_q;
        grant_d        = grant_q;
        ack_d          = '0;
        result_valid_d = 1'b0;
        result_d       = result_q;
        result_id_d    = result_id_q;
        served_cnt_d   = served_cnt_q;
        vote_reg_d     = vote_reg_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    sel_d   = pickIdx;
                    grant_d = pickOneHot;
                    state_d = LOAD;
                end else begin
                    grant_d = '0;
                end
            end
            LOAD: begin
                if (!reqSel) begin
                    grant_d  = '0;
                    rr_ptr_d = nextPtr;
                    state_d  = IDLE;
                end else begin
                    vote_reg_d = selVote;
                    state_d    = EVAL;
                end
            end
            EVAL: begin
                if (!reqSel) begin
                    grant_d  = '0;
                    rr_ptr_d = nextPtr;
                    state_d  = IDLE;
                end else begin
                    result_d       = majOut;
                    result_id_d    = sel_q;
                    ack_d          = grant_q;
                    result_valid_d = 1'b1;
                    state_d        = DONE;
                end
            end
            DONE: begin
                grant_d      = '0;
                served_cnt_d = served_cnt_q + CNT_W'(1);
                rr_ptr_d     = nextPtr;
                state_d      = IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything and discards any in-flight transaction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            rr_ptr_q       <= '0;
            sel_q          <= '0;
            grant_q        <= '0;
            ack_q          <= '0;
            result_valid_q <= 1'b0;
            result_q       <= 1'b0;
            result_id_q    <= '0;
            served_cnt_q   <= '0;
            vote_reg_q     <= '0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            sel_q          <= sel_d;
            grant_q        <= grant_d;
            ack_q          <= ack_d;
            result_valid_q <= result_valid_d;
            result_q       <= result_d;
            result_id_q    <= result_id_d;
            served_cnt_q   <= served_cnt_d;
            vote_reg_q     <= vote_reg_d;
        end
    end

    assign grant        = grant_q;
    assign ack          = ack_q;
    assign result_valid = result_valid_q;
    assign result       = result_q;
    assign result_id    = result_id_q;
    assign served_cnt   = served_cnt_q;

endmodule

// File: tb/tb_majority_vote_arbiter.sv
// Directed bench for majority_vote_arbiter (N_REQ=4, CNT_W=8). Inputs are
// driven and outputs sampled on the falling clock edge.
module tb_majority_vote_arbiter;

    logic        clk;
    logic        reset_n;
    logic [3:0]  req;
    logic [19:0] vote_data;
    logic [3:0]  grant;
    logic [3:0]  ack;
    logic        result_valid;
    logic        result;
    logic [2:0]  result_id;
    logic [7:0]  served_cnt;

    int          nCompared;
    int          nMismatched;
    logic [7:0]  expCnt;
    logic        lastRes;
    logic [2:0]  lastId;

    majority_vote_arbiter #(.N_REQ(4), .CNT_W(8)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req          (req),
        .vote_data    (vote_data),
        .grant        (grant),
        .ack          (ack),
        .result_valid (result_valid),
        .result       (result),
        .result_id    (result_id),
        .served_cnt   (served_cnt)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        if (observed !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] reqVal, input logic [19:0] voteVal);
        req       = reqVal;
        vote_data = voteVal;
    endtask

    // One full transaction expected to be granted to expIdx; other slices carry ~vote,
    // and vote_data is scrambled after LOAD to show it is no longer sampled.
    task automatic serve(input logic [3:0] reqMask, input int expIdx, input logic [4:0] vote, input string tag);
        logic [3:0]  oh;
        logic        expRes;
        logic [19:0] va;
        oh     = 4'b0001 << expIdx;
        expRes = ($countones(vote) >= 3);
        va     = {4{~vote}};
        va[5*expIdx +: 5] = vote;
        applyStimulus(reqMask, va);
        @(negedge clk);
        checkOutput({tag, ".grant"}, 32'(grant), 32'(oh));
        checkOutput({tag, ".earlyAck"}, 32'(ack), 32'd0);
        @(negedge clk);
        applyStimulus(reqMask, ~va);
        @(negedge clk);
        checkOutput({tag, ".ack"}, 32'(ack), 32'(oh));
        checkOutput({tag, ".valid"}, 32'(result_valid), 32'd1);
        checkOutput({tag, ".result"}, 32'(result), 32'(expRes));
        checkOutput({tag, ".id"}, 32'(result_id), 32'(expIdx));
        checkOutput({tag, ".grantHeld"}, 32'(grant), 32'(oh));
        applyStimulus(reqMask & ~oh, ~va);
        expCnt = expCnt + 8'd1;
        @(negedge clk);
        checkOutput({tag, ".grantClr"}, 32'(grant), 32'd0);
        checkOutput({tag, ".ackClr"}, 32'(ack), 32'd0);
        checkOutput({tag, ".validClr"}, 32'(result_valid), 32'd0);
        checkOutput({tag, ".cnt"}, 32'(served_cnt), 32'(expCnt));
        checkOutput({tag, ".resHold"}, 32'(result), 32'(expRes));
        lastRes = expRes;
        lastId  = 3'(expIdx);
    endtask

    // Main directed sequence.
    initial begin
        nCompared   = 0;
        nMismatched = 0;
        expCnt      = 8'd0;
        lastRes     = 1'b0;
        lastId      = 3'd0;
        reset_n     = 1'b0;
        applyStimulus(4'b0000, 20'd0);
        repeat (2) @(negedge clk);
        checkOutput("rst.grant", 32'(grant), 32'd0);
        checkOutput("rst.ack", 32'(ack), 32'd0);
        checkOutput("rst.valid", 32'(result_valid), 32'd0);
        checkOutput("rst.result", 32'(result), 32'd0);
        checkOutput("rst.id", 32'(result_id), 32'd0);
        checkOutput("rst.cnt", 32'(served_cnt), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("idle.grant", 32'(grant), 32'd0);

        serve(4'b0100, 2, 5'b10110, "single2");

        // Abort in LOAD: rr_ptr=3, scan 3,0,1 -> picks 1; drop req during LOAD.
        applyStimulus(4'b0010, 20'hAAAAA);
        @(negedge clk);
        checkOutput("abortL.grant", 32'(grant), 32'b0010);
        applyStimulus(4'b0000, 20'hAAAAA);
        @(negedge clk);
        checkOutput("abortL.grantClr", 32'(grant), 32'd0);
        checkOutput("abortL.ack", 32'(ack), 32'd0);
        checkOutput("abortL.valid", 32'(result_valid), 32'd0);
        checkOutput("abortL.result", 32'(result), 32'(lastRes));
        checkOutput("abortL.id", 32'(result_id), 32'(lastId));
        checkOutput("abortL.cnt", 32'(served_cnt), 32'(expCnt));
        serve(4'b1111, 2, 5'b11001, "afterAbort");

        serve(4'b0001, 0, 5'b00011, "low0");
        for (int n = 0; n < 32; n++) begin
            serve(4'b0001, 0, 5'(n), "exh");
        end

        // Abort in EVAL: rr_ptr=1, only req[3] -> picks 3, dropped during EVAL.
        applyStimulus(4'b1000, 20'h55555);
        @(negedge clk);
        checkOutput("abortE.grant", 32'(grant), 32'b1000);
        @(negedge clk);
        applyStimulus(4'b0000, 20'h55555);
        @(negedge clk);
        checkOutput("abortE.grantClr", 32'(grant), 32'd0);
        checkOutput("abortE.ack", 32'(ack), 32'd0);
        checkOutput("abortE.valid", 32'(result_valid), 32'd0);
        checkOutput("abortE.result", 32'(result), 32'(lastRes));
        checkOutput("abortE.cnt", 32'(served_cnt), 32'(expCnt));
        serve(4'b1001, 0, 5'b11111, "ptrWrap");

        // Reset asserted during EVAL clears all outputs without waiting for a clock edge.
        applyStimulus(4'b0100, 20'hFFFFF);
        @(negedge clk);
        checkOutput("rstE.grant", 32'(grant), 32'b0100);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkOutput("rstE.grant0", 32'(grant), 32'd0);
        checkOutput("rstE.ack0", 32'(ack), 32'd0);
        checkOutput("rstE.valid0", 32'(result_valid), 32'd0);
        checkOutput("rstE.result0", 32'(result), 32'd0);
        checkOutput("rstE.id0", 32'(result_id), 32'd0);
        checkOutput("rstE.cnt0", 32'(served_cnt), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        expCnt  = 8'd0;

        // Round robin from rr_ptr=0 with all requesters re-raising after each ack.
        serve(4'b1111, 0, 5'b00111, "rr0");
        serve(4'b1111, 1, 5'b01000, "rr1");
        serve(4'b1111, 2, 5'b11100, "rr2");
        serve(4'b1111, 3, 5'b10001, "rr3");
        serve(4'b1111, 0, 5'b01101, "rr0b");

        // Result and result_id hold across idle cycles.
        applyStimulus(4'b0000, 20'd0);
        repeat (3) @(negedge clk);
        checkOutput("hold.result", 32'(result), 32'(lastRes));
        checkOutput("hold.id", 32'(result_id), 32'(lastId));
        checkOutput("hold.valid", 32'(result_valid), 32'd0);
        checkOutput("hold.grant", 32'(grant), 32'd0);

        // Drive the counter to 255, then one more evaluation wraps it to 0.
        for (int n = 0; n < 300 && expCnt != 8'hFF; n++) begin
            serve(4'b0001, 0, 5'(n), "fill");
        end
        checkOutput("cnt.at255", 32'(served_cnt), 32'hFF);
        serve(4'b0010, 1, 5'b10101, "wrap");
        checkOutput("cnt.wrapped", 32'(served_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
